// File: rtl/ospfb_frame_chk.sv
// OSPFB FFT output frame checker.
// Aligns to frame boundaries on the incoming AXIS stream, then checks every frame
// for length, bin index and tlast placement. Reports the peak-magnitude bin of each
// good frame. An optional periodic tready stall exercises upstream backpressure.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | disabled, tready low, partial frame state discarded
// S_SYNC | accepting and discarding beats until a tlast marks alignment
// S_RUN  | aligned; every beat is checked and tracked for the peak bin
module ospfb_frame_chk #(
    parameter int WIDTH        = 16,
    parameter int FFT_LEN      = 64,
    parameter int TUSER_WID    = 8,
    parameter int CNT_WID      = 16,
    parameter int READY_PERIOD = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [2*WIDTH-1:0]         s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    input  logic [TUSER_WID-1:0]       s_axis_tuser,
    output logic [CNT_WID-1:0]         frame_cnt,
    output logic [CNT_WID-1:0]         err_cnt,
    output logic                       err_tlast_early,
    output logic                       err_tlast_missing,
    output logic                       err_index,
    output logic                       peak_valid,
    output logic [$clog2(FFT_LEN)-1:0] peak_bin,
    output logic [WIDTH:0]             peak_mag
);
    localparam int IDX_W = $clog2(FFT_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SYNC = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 thr_stall;
    logic                 ready;
    logic                 beat;
    logic                 run_beat;

    logic [IDX_W-1:0]     idx_q;
    logic                 frame_bad_q;
    logic [WIDTH:0]       run_max_q;
    logic [IDX_W-1:0]     run_bin_q;

    logic [WIDTH:0]       mag;
    logic [TUSER_WID-1:0] idx_ext;
    logic                 last_bin;
    logic                 e_index;
    logic                 e_early;
    logic                 e_missing;
    logic                 frame_end;
    logic                 frame_bad_now;
    logic                 take;
    logic [WIDTH:0]       cur_max;
    logic [IDX_W-1:0]     cur_bin;

    // Exact |v| of a signed component, one bit wider so -2^(WIDTH-1) fits.
    function automatic logic [WIDTH:0] abs_ext(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] x;
        x = {v[WIDTH-1], v};
        return x[WIDTH] ? (~x + 1'b1) : x;
    endfunction

    // tready comes from registered state and en only, never from tvalid; gating
    // with en means no beat is taken on the cycle the checker is being disabled.
    assign ready         = en && (state_q != S_IDLE) && !thr_stall;
    assign s_axis_tready = ready;
    assign beat          = s_axis_tvalid && ready;
    assign run_beat      = beat && (state_q == S_RUN);

    // Periodic stall: tready drops for one cycle in every READY_PERIOD.
    generate
        if (READY_PERIOD >= 2) begin : g_thr
            localparam int TW = $clog2(READY_PERIOD);
            localparam logic [TW-1:0] TOP = TW'(READY_PERIOD - 1);
            logic [TW-1:0] thr_cnt;

            // Down-counter, reloaded while idle so each enable starts a fresh period.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    thr_cnt <= TOP;
                end else if (state_q == S_IDLE || thr_cnt == '0) begin
                    thr_cnt <= TOP;
                end else begin
                    thr_cnt <= thr_cnt - 1'b1;
                end
            end

            assign thr_stall = (thr_cnt == '0);
        end else begin : g_nothr
            assign thr_stall = 1'b0;
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; dropping en always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (en) state_d = S_SYNC;
            S_SYNC: if (beat && s_axis_tlast) state_d = S_RUN;
            S_RUN:  state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
        if (!en) state_d = S_IDLE;
    end

    // Per-beat checks and running-maximum candidate for the current beat.
    always_comb begin
        mag           = abs_ext(s_axis_tdata[WIDTH-1:0]) + abs_ext(s_axis_tdata[2*WIDTH-1:WIDTH]);
        idx_ext       = TUSER_WID'(idx_q);
        last_bin      = &idx_q;
        e_index       = (s_axis_tuser != idx_ext);
        e_early       = s_axis_tlast && !last_bin;
        e_missing     = !s_axis_tlast && last_bin;
        frame_end     = s_axis_tlast || last_bin;
        frame_bad_now = frame_bad_q || e_index || e_early || e_missing;
        // Strictly greater keeps the lower bin on ties; bin 0 seeds the max.
        take          = (idx_q == '0) || (mag > run_max_q);
        cur_max       = take ? mag : run_max_q;
        cur_bin       = take ? idx_q : run_bin_q;
    end

    // Frame tracking, sticky flags, saturating counters and peak reporting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q             <= '0;
            frame_bad_q       <= 1'b0;
            run_max_q         <= '0;
            run_bin_q         <= '0;
            frame_cnt         <= '0;
            err_cnt           <= '0;
            err_tlast_early   <= 1'b0;
            err_tlast_missing <= 1'b0;
            err_index         <= 1'b0;
            peak_valid        <= 1'b0;
            peak_bin          <= '0;
            peak_mag          <= '0;
        end else begin
            peak_valid <= 1'b0;
            if (state_q != S_RUN) begin
                idx_q       <= '0;
                frame_bad_q <= 1'b0;
            end else if (run_beat) begin
                if (e_index)   err_index         <= 1'b1;
                if (e_early)   err_tlast_early   <= 1'b1;
                if (e_missing) err_tlast_missing <= 1'b1;
                run_max_q <= cur_max;
                run_bin_q <= cur_bin;
                if (frame_end) begin
                    idx_q       <= '0;
                    frame_bad_q <= 1'b0;
                    if (frame_bad_now) begin
                        if (!(&err_cnt)) err_cnt <= err_cnt + 1'b1;
                    end else begin
                        peak_valid <= 1'b1;
                        peak_bin   <= cur_bin;
                        peak_mag   <= cur_max;
                        if (!(&frame_cnt)) frame_cnt <= frame_cnt + 1'b1;
                    end
                end else begin
                    idx_q       <= idx_q + 1'b1;
                    frame_bad_q <= frame_bad_now;
                end
            end
        end
    end

endmodule

// File: tb/tb_ospfb_frame_chk.sv
// Testbench for ospfb_frame_chk: an unthrottled instance (a) and a READY_PERIOD=4
// instance (b) share the stream inputs; only the enabled one consumes beats.
module tb_ospfb_frame_chk;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_a = 1'b0;
    logic        en_b = 1'b0;
    logic [31:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic [7:0]  tuser = '0;

    logic        tready_a, tready_b;
    logic [15:0] frame_cnt_a, err_cnt_a, frame_cnt_b, err_cnt_b;
    logic        early_a, missing_a, index_a, peak_valid_a;
    logic        early_b, missing_b, index_b, peak_valid_b;
    logic [5:0]  peak_bin_a, peak_bin_b;
    logic [16:0] peak_mag_a, peak_mag_b;

    always #5 clk = ~clk;

    ospfb_frame_chk dut_a (
        .clk(clk), .rst(rst), .en(en_a),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready_a),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .frame_cnt(frame_cnt_a), .err_cnt(err_cnt_a),
        .err_tlast_early(early_a), .err_tlast_missing(missing_a), .err_index(index_a),
        .peak_valid(peak_valid_a), .peak_bin(peak_bin_a), .peak_mag(peak_mag_a)
    );

    ospfb_frame_chk #(.READY_PERIOD(4)) dut_b (
        .clk(clk), .rst(rst), .en(en_b),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready_b),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .frame_cnt(frame_cnt_b), .err_cnt(err_cnt_b),
        .err_tlast_early(early_b), .err_tlast_missing(missing_b), .err_index(index_b),
        .peak_valid(peak_valid_b), .peak_bin(peak_bin_b), .peak_mag(peak_mag_b)
    );

    typedef struct {
        int bin;
        int mag;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    int total = 0;
    int bad = 0;
    int peaks_a = 0;
    int peaks_b = 0;
    int re_v[64];
    int im_v[64];
    int exp_frames[2];
    int exp_errs[2];
    bit exp_early[2];
    bit exp_missing[2];
    bit exp_index[2];

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Scoreboard: every peak_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (peak_valid_a) begin
            peaks_a++;
            total++;
            if (q_a.size() == 0) begin
                bad++;
                $display("FAIL peak_a_unexpected got bin=%0d mag=%0d want no pulse", peak_bin_a, peak_mag_a);
            end else begin
                ea = q_a.pop_front();
                if (peak_bin_a !== 6'(ea.bin) || peak_mag_a !== 17'(ea.mag)) begin
                    bad++;
                    $display("FAIL peak_a got bin=%0d mag=%0d want bin=%0d mag=%0d",
                             peak_bin_a, peak_mag_a, ea.bin, ea.mag);
                end
            end
        end
        if (peak_valid_b) begin
            peaks_b++;
            total++;
            if (q_b.size() == 0) begin
                bad++;
                $display("FAIL peak_b_unexpected got bin=%0d mag=%0d want no pulse", peak_bin_b, peak_mag_b);
            end else begin
                eb = q_b.pop_front();
                if (peak_bin_b !== 6'(eb.bin) || peak_mag_b !== 17'(eb.mag)) begin
                    bad++;
                    $display("FAIL peak_b got bin=%0d mag=%0d want bin=%0d mag=%0d",
                             peak_bin_b, peak_mag_b, eb.bin, eb.mag);
                end
            end
        end
    end

    task automatic set_pattern(input int kind);
        for (int b = 0; b < 64; b++) begin
            re_v[b] = 1;
            im_v[b] = 1;
        end
        case (kind)
            0: begin re_v[17] = 100;    im_v[17] = -50;    end
            1: begin re_v[3]  = -32768; im_v[3]  = -32768; end
            2: begin re_v[2]  = 200;    im_v[2]  = 0;
                     re_v[9]  = 0;      im_v[9]  = -200;   end
            default: ;
        endcase
    endtask

    task automatic idle(input int n);
        tvalid = 1'b0;
        tlast  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Drive one beat at a negedge and hold it until the selected DUT takes it.
    task automatic send_beat(input int sel, input int b, input logic tl, input int tu);
        int   n;
        logic r;
        tdata  = {16'(im_v[b]), 16'(re_v[b])};
        tuser  = 8'(tu);
        tlast  = tl;
        tvalid = 1'b1;
        n = 0;
        r = 1'b0;
        while (!r && n <= 100) begin
            r = (sel != 0) ? tready_b : tready_a;
            @(negedge clk);
            n++;
        end
        if (!r) begin
            total++;
            bad++;
            $display("FAIL beat_timeout sel=%0d bin=%0d got no accept in %0d cycles want accept", sel, b, n);
        end
    endtask

    // tlast_bin: 63 normal, <63 early tlast, -1 no tlast. bad_bin: bin with wrong tuser, -1 none.
    task automatic send_frame(input int sel, input int tlast_bin, input int bad_bin,
                              input bit counted, input int first_bin);
        int   last, best, bb, m;
        bit   good;
        exp_t e;
        last = (tlast_bin >= 0) ? tlast_bin : 63;
        good = (tlast_bin == 63) && (bad_bin < 0);
        if (counted) begin
            if (good) begin
                best = iabs(re_v[0]) + iabs(im_v[0]);
                bb   = 0;
                for (int b = 1; b < 64; b++) begin
                    m = iabs(re_v[b]) + iabs(im_v[b]);
                    if (m > best) begin
                        best = m;
                        bb   = b;
                    end
                end
                e.bin = bb;
                e.mag = best;
                if (sel != 0) q_b.push_back(e);
                else          q_a.push_back(e);
                exp_frames[sel]++;
            end else begin
                exp_errs[sel]++;
                if (tlast_bin >= 0 && tlast_bin < 63) exp_early[sel] = 1'b1;
                if (tlast_bin < 0)                    exp_missing[sel] = 1'b1;
                if (bad_bin >= 0)                     exp_index[sel] = 1'b1;
            end
        end
        for (int b = first_bin; b <= last; b++)
            send_beat(sel, b, (b == tlast_bin), (b == bad_bin) ? b + 1 : b);
    endtask

    task automatic test_reset();
        total++;
        if (frame_cnt_a !== 16'd0 || err_cnt_a !== 16'd0) begin
            bad++;
            $display("FAIL reset_cnt got frame=%0d err=%0d want 0 0", frame_cnt_a, err_cnt_a);
        end
        total++;
        if ({early_a, missing_a, index_a, peak_valid_a, tready_a} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got %b want 00000", {early_a, missing_a, index_a, peak_valid_a, tready_a});
        end
        total++;
        if (peak_bin_a !== 6'd0 || peak_mag_a !== 17'd0) begin
            bad++;
            $display("FAIL reset_peak got bin=%0d mag=%0d want 0 0", peak_bin_a, peak_mag_a);
        end
    endtask

    task automatic test_clean();
        int p0;
        p0 = peaks_a;
        en_a = 1'b1;
        set_pattern(0);
        send_frame(0, 63, -1, 1'b0, 56);
        for (int f = 0; f < 3; f++) send_frame(0, 63, -1, 1'b1, 0);
        idle(3);
        total++;
        if (frame_cnt_a !== 16'd3 || err_cnt_a !== 16'd0) begin
            bad++;
            $display("FAIL clean_cnt got frame=%0d err=%0d want 3 0", frame_cnt_a, err_cnt_a);
        end
        total++;
        if ({early_a, missing_a, index_a} !== 3'b0) begin
            bad++;
            $display("FAIL clean_flags got %b want 000", {early_a, missing_a, index_a});
        end
        total++;
        if (peaks_a - p0 !== 3) begin
            bad++;
            $display("FAIL clean_pulses got %0d want 3", peaks_a - p0);
        end
        total++;
        if (peak_bin_a !== 6'd17 || peak_mag_a !== 17'd150) begin
            bad++;
            $display("FAIL clean_peak got bin=%0d mag=%0d want 17 150", peak_bin_a, peak_mag_a);
        end
    endtask

    task automatic test_tlast_early();
        int p0;
        p0 = peaks_a;
        send_frame(0, 10, -1, 1'b1, 0);
        send_frame(0, 63, -1, 1'b1, 0);
        idle(3);
        total++;
        if (early_a !== 1'b1 || missing_a !== 1'b0 || index_a !== 1'b0) begin
            bad++;
            $display("FAIL early_flags got e=%b m=%b i=%b want 1 0 0", early_a, missing_a, index_a);
        end
        total++;
        if (err_cnt_a !== 16'(exp_errs[0]) || frame_cnt_a !== 16'(exp_frames[0])) begin
            bad++;
            $display("FAIL early_cnt got err=%0d frame=%0d want %0d %0d",
                     err_cnt_a, frame_cnt_a, exp_errs[0], exp_frames[0]);
        end
        total++;
        if (peaks_a - p0 !== 1) begin
            bad++;
            $display("FAIL early_pulses got %0d want 1", peaks_a - p0);
        end
    endtask

    task automatic test_tlast_missing();
        send_frame(0, -1, -1, 1'b1, 0);
        send_frame(0, 63, -1, 1'b1, 0);
        idle(3);
        total++;
        if (missing_a !== 1'b1 || index_a !== 1'b0) begin
            bad++;
            $display("FAIL missing_flags got m=%b i=%b want 1 0", missing_a, index_a);
        end
        total++;
        if (err_cnt_a !== 16'(exp_errs[0]) || frame_cnt_a !== 16'(exp_frames[0])) begin
            bad++;
            $display("FAIL missing_cnt got err=%0d frame=%0d want %0d %0d",
                     err_cnt_a, frame_cnt_a, exp_errs[0], exp_frames[0]);
        end
    endtask

    task automatic test_index();
        int p0;
        p0 = peaks_a;
        send_frame(0, 63, 5, 1'b1, 0);
        idle(2);
        total++;
        if (index_a !== 1'b1 || peaks_a !== p0 || err_cnt_a !== 16'(exp_errs[0])) begin
            bad++;
            $display("FAIL index_bad got i=%b pulses=%0d err=%0d want 1 0 %0d",
                     index_a, peaks_a - p0, err_cnt_a, exp_errs[0]);
        end
        send_frame(0, 63, -1, 1'b1, 0);
        idle(3);
        total++;
        if (frame_cnt_a !== 16'(exp_frames[0]) || peaks_a - p0 !== 1) begin
            bad++;
            $display("FAIL index_recover got frame=%0d pulses=%0d want %0d 1",
                     frame_cnt_a, peaks_a - p0, exp_frames[0]);
        end
    endtask

    task automatic test_min_mag();
        set_pattern(1);
        send_frame(0, 63, -1, 1'b1, 0);
        idle(3);
        total++;
        if (peak_bin_a !== 6'd3 || peak_mag_a !== 17'd65536) begin
            bad++;
            $display("FAIL min_mag got bin=%0d mag=%0d want 3 65536", peak_bin_a, peak_mag_a);
        end
    endtask

    task automatic test_tie();
        set_pattern(2);
        send_frame(0, 63, -1, 1'b1, 0);
        idle(3);
        total++;
        if (peak_bin_a !== 6'd2 || peak_mag_a !== 17'd200) begin
            bad++;
            $display("FAIL tie got bin=%0d mag=%0d want 2 200", peak_bin_a, peak_mag_a);
        end
    endtask

    task automatic test_en_drop();
        set_pattern(0);
        for (int b = 0; b < 30; b++) send_beat(0, b, 1'b0, b);
        en_a = 1'b0;
        idle(3);
        total++;
        if (tready_a !== 1'b0 || frame_cnt_a !== 16'(exp_frames[0])) begin
            bad++;
            $display("FAIL en_drop_idle got tready=%b frame=%0d want 0 %0d",
                     tready_a, frame_cnt_a, exp_frames[0]);
        end
        en_a = 1'b1;
        send_frame(0, 63, -1, 1'b0, 0);
        idle(2);
        total++;
        if (frame_cnt_a !== 16'(exp_frames[0])) begin
            bad++;
            $display("FAIL en_drop_sync got frame=%0d want %0d", frame_cnt_a, exp_frames[0]);
        end
        send_frame(0, 63, -1, 1'b1, 0);
        idle(3);
        total++;
        if (frame_cnt_a !== 16'(exp_frames[0]) || err_cnt_a !== 16'(exp_errs[0])) begin
            bad++;
            $display("FAIL en_drop_resume got frame=%0d err=%0d want %0d %0d",
                     frame_cnt_a, err_cnt_a, exp_frames[0], exp_errs[0]);
        end
    endtask

    task automatic test_throttle();
        en_a   = 1'b0;
        tvalid = 1'b1;
        tlast  = 1'b0;
        tuser  = '0;
        @(negedge clk);
        en_b = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            total++;
            if (tready_b !== ((k % 4) != 3)) begin
                bad++;
                $display("FAIL throttle_ready cycle=%0d got %b want %b", k, tready_b, ((k % 4) != 3));
            end
            @(negedge clk);
        end
        set_pattern(0);
        send_frame(1, 63, -1, 1'b0, 56);
        for (int f = 0; f < 3; f++) send_frame(1, 63, -1, 1'b1, 0);
        idle(3);
        total++;
        if (frame_cnt_b !== 16'd3 || err_cnt_b !== 16'd0 || peaks_b !== 3) begin
            bad++;
            $display("FAIL throttle_cnt got frame=%0d err=%0d pulses=%0d want 3 0 3",
                     frame_cnt_b, err_cnt_b, peaks_b);
        end
        total++;
        if (peak_bin_b !== 6'd17 || peak_mag_b !== 17'd150 || {early_b, missing_b, index_b} !== 3'b0) begin
            bad++;
            $display("FAIL throttle_peak got bin=%0d mag=%0d flags=%b want 17 150 000",
                     peak_bin_b, peak_mag_b, {early_b, missing_b, index_b});
        end
        en_b = 1'b0;
    endtask

    task automatic test_reset_mid();
        en_a = 1'b1;
        set_pattern(0);
        send_frame(0, 63, -1, 1'b0, 56);
        for (int b = 0; b < 20; b++) send_beat(0, b, 1'b0, b);
        #2 rst = 1'b1;
        #1;
        total++;
        if (frame_cnt_a !== 16'd0 || err_cnt_a !== 16'd0 || peak_bin_a !== 6'd0 || peak_mag_a !== 17'd0) begin
            bad++;
            $display("FAIL reset_mid_cnt got frame=%0d err=%0d bin=%0d mag=%0d want 0 0 0 0",
                     frame_cnt_a, err_cnt_a, peak_bin_a, peak_mag_a);
        end
        total++;
        if ({early_a, missing_a, index_a, peak_valid_a, tready_a} !== 5'b0) begin
            bad++;
            $display("FAIL reset_mid_flags got %b want 00000", {early_a, missing_a, index_a, peak_valid_a, tready_a});
        end
        exp_frames[0]  = 0;
        exp_errs[0]    = 0;
        exp_early[0]   = 1'b0;
        exp_missing[0] = 1'b0;
        exp_index[0]   = 1'b0;
        q_a.delete();
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        send_frame(0, 63, -1, 1'b0, 0);
        idle(2);
        total++;
        if (frame_cnt_a !== 16'd0) begin
            bad++;
            $display("FAIL reset_mid_sync got frame=%0d want 0", frame_cnt_a);
        end
        send_frame(0, 63, -1, 1'b1, 0);
        idle(3);
        total++;
        if (frame_cnt_a !== 16'd1 || peak_bin_a !== 6'd17 || peak_mag_a !== 17'd150) begin
            bad++;
            $display("FAIL reset_mid_resume got frame=%0d bin=%0d mag=%0d want 1 17 150",
                     frame_cnt_a, peak_bin_a, peak_mag_a);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            exp_frames[s]  = 0;
            exp_errs[s]    = 0;
            exp_early[s]   = 1'b0;
            exp_missing[s] = 1'b0;
            exp_index[s]   = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_clean();
        test_tlast_early();
        test_tlast_missing();
        test_index();
        test_min_mag();
        test_tie();
        test_en_drop();
        test_throttle();
        test_reset_mid();
        idle(2);
        total++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got a=%0d b=%0d pending want 0 0", q_a.size(), q_b.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
